store_lane_mux: RTL and testbench



---
 rtl/store_lane_mux_if.sv | 33 +++
 rtl/store_lane_mux.sv | 144 ++++++++++++++
 tb/tb_store_lane_mux.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/store_lane_mux_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | store_lane_mux_if : store request / lane-steered beat bundle    |
// | Revision 1.0                                                    |
// +-----------------------------------------------------------------+
interface store_lane_mux_if #(
  parameter int DATA_W = 32
);
  localparam int NB = DATA_W / 8;
  localparam int AW = $clog2(NB);

  logic              in_valid;
  logic              in_ready;
  logic [AW-1:0]     in_addr;
  logic [1:0]        in_size;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [NB-1:0]     out_be;
  logic              out_err;

  modport slave (
    input  in_valid, in_addr, in_size, in_data, out_ready,
    output in_ready, out_valid, out_data, out_be, out_err
  );

  modport master (
    output in_valid, in_addr, in_size, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_be, out_err
  );
endinterface
`default_nettype wire

// File: rtl/store_lane_mux.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | store_lane_mux : store-data lane replication and byte enables,  |
// | buffered behind a two-entry skid stage.      Revision 1.0       |
// +-----------------------------------------------------------------+
module store_lane_mux #(
  parameter int DATA_W     = 32,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  store_lane_mux_if.slave  bus
);
  localparam int NB = DATA_W / 8;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [3:0]        size_bytes;
  logic              illegal;
  logic              misaligned;
  logic [NB-1:0]     base_mask;
  logic [NB-1:0]     be_le;
  logic [NB-1:0]     be_lanes;
  logic [DATA_W-1:0] lane_data;
  logic [DATA_W-1:0] beat_data;
  logic [NB-1:0]     beat_be;
  logic              beat_err;

  always_comb begin
    size_bytes = 4'd1 << bus.in_size;
    illegal    = int'(size_bytes) > NB;
    misaligned = (4'(bus.in_addr) & (size_bytes - 4'd1)) != 4'd0;
    for (int i = 0; i < NB; i++) begin
      base_mask[i] = i < int'(size_bytes);
    end
    be_le = base_mask << bus.in_addr;
    // Lane i takes source byte (i mod S); S is a power of two so a mask suffices.
    for (int i = 0; i < NB; i++) begin
      lane_data[8*i +: 8] = bus.in_data[8*(i & (int'(size_bytes) - 1)) +: 8];
    end
  end

  generate
    if (BIG_ENDIAN) begin : g_big_endian
      always_comb begin
        for (int i = 0; i < NB; i++) begin
          be_lanes[i] = be_le[NB-1-i];
        end
      end
    end else begin : g_little_endian
      assign be_lanes = be_le;
    end
  endgenerate

  assign beat_err  = illegal | misaligned;
  assign beat_data = illegal ? bus.in_data : lane_data;
  assign beat_be   = beat_err ? '0 : be_lanes;

  logic [1:0]        state_q,    state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [NB-1:0]     out_be_q,   out_be_d;
  logic              out_err_q,  out_err_d;
  logic [DATA_W-1:0] sk_data_q,  sk_data_d;
  logic [NB-1:0]     sk_be_q,    sk_be_d;
  logic              sk_err_q,   sk_err_d;
  logic              accept;
  logic              drain;

  // in_ready depends only on state, so backpressure never reaches the producer combinationally.
  assign bus.in_ready  = (state_q != ST_FULL);
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.out_data  = out_data_q;
  assign bus.out_be    = out_be_q;
  assign bus.out_err   = out_err_q;

  assign accept = bus.in_valid && (state_q != ST_FULL);
  assign drain  = bus.out_ready && (state_q != ST_EMPTY);

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_be_d   = out_be_q;
    out_err_d  = out_err_q;
    sk_data_d  = sk_data_q;
    sk_be_d    = sk_be_q;
    sk_err_d   = sk_err_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_data_d = beat_data;
          out_be_d   = beat_be;
          out_err_d  = beat_err;
          state_d    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          out_data_d = beat_data;
          out_be_d   = beat_be;
          out_err_d  = beat_err;
        end else if (accept) begin
          sk_data_d = beat_data;
          sk_be_d   = beat_be;
          sk_err_d  = beat_err;
          state_d   = ST_FULL;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drain) begin
          out_data_d = sk_data_q;
          out_be_d   = sk_be_q;
          out_err_d  = sk_err_q;
          state_d    = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_be_q   <= '0;
      out_err_q  <= 1'b0;
      sk_data_q  <= '0;
      sk_be_q    <= '0;
      sk_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_be_q   <= out_be_d;
      out_err_q  <= out_err_d;
      sk_data_q  <= sk_data_d;
      sk_be_q    <= sk_be_d;
      sk_err_q   <= sk_err_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_store_lane_mux.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_store_lane_mux : three DUT variants (LE32, BE32, LE64) fed   |
// | identical stimulus and checked against a queue model. Rev 1.0   |
// +-----------------------------------------------------------------+
module tb_store_lane_mux;
  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  be;
    logic        err;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  in_addr;
  logic [1:0]  in_size;
  logic [63:0] in_data;
  logic        out_ready;

  int checks = 0;
  int errors = 0;
  beat_t exp_q [3][$];

  always #5 clk = ~clk;

  store_lane_mux_if #(.DATA_W(32)) if_le32 ();
  store_lane_mux_if #(.DATA_W(32)) if_be32 ();
  store_lane_mux_if #(.DATA_W(64)) if_le64 ();

  assign if_le32.in_valid = in_valid;
  assign if_le32.in_addr  = in_addr[1:0];
  assign if_le32.in_size  = in_size;
  assign if_le32.in_data  = in_data[31:0];
  assign if_le32.out_ready = out_ready;
  assign if_be32.in_valid = in_valid;
  assign if_be32.in_addr  = in_addr[1:0];
  assign if_be32.in_size  = in_size;
  assign if_be32.in_data  = in_data[31:0];
  assign if_be32.out_ready = out_ready;
  assign if_le64.in_valid = in_valid;
  assign if_le64.in_addr  = in_addr;
  assign if_le64.in_size  = in_size;
  assign if_le64.in_data  = in_data;
  assign if_le64.out_ready = out_ready;

  store_lane_mux #(.DATA_W(32), .BIG_ENDIAN(1'b0)) u_le32 (.clk(clk), .rst(rst), .bus(if_le32));
  store_lane_mux #(.DATA_W(32), .BIG_ENDIAN(1'b1)) u_be32 (.clk(clk), .rst(rst), .bus(if_be32));
  store_lane_mux #(.DATA_W(64), .BIG_ENDIAN(1'b0)) u_le64 (.clk(clk), .rst(rst), .bus(if_le64));

  // Reference: byte k of the result is source byte (k % S); lane k enabled when addr <= k < addr+S.
  function automatic beat_t model(input int nb, input bit big, input logic [2:0] addr_in,
                                  input logic [1:0] size, input logic [63:0] data);
    beat_t b;
    int s;
    int a;
    bit bad_size;
    b        = '0;
    s        = 1 << size;
    a        = int'(addr_in) % nb;
    bad_size = s > nb;
    for (int k = 0; k < nb; k++) begin
      b.d[8*k +: 8] = bad_size ? data[8*k +: 8] : data[8*(k % s) +: 8];
    end
    b.err = bad_size || ((a % s) != 0);
    if (!b.err) begin
      for (int k = 0; k < nb; k++) begin
        if (k >= a && k < a + s) b.be[big ? nb - 1 - k : k] = 1'b1;
      end
    end
    return b;
  endfunction

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic observe(input int k, output logic ov, output logic ir, output logic [63:0] od,
                         output logic [7:0] obe, output logic oe);
    case (k)
      0: begin ov = if_le32.out_valid; ir = if_le32.in_ready; od = {32'd0, if_le32.out_data};
               obe = {4'd0, if_le32.out_be}; oe = if_le32.out_err; end
      1: begin ov = if_be32.out_valid; ir = if_be32.in_ready; od = {32'd0, if_be32.out_data};
               obe = {4'd0, if_be32.out_be}; oe = if_be32.out_err; end
      default: begin ov = if_le64.out_valid; ir = if_le64.in_ready; od = if_le64.out_data;
               obe = if_le64.out_be; oe = if_le64.out_err; end
    endcase
  endtask

  // Compare all instances against queue occupancy and content, then advance the model.
  task automatic sample();
    logic ov, ir, oe;
    logic [63:0] od;
    logic [7:0] obe;
    beat_t b;
    bit exp_ready;
    for (int k = 0; k < 3; k++) begin
      observe(k, ov, ir, od, obe, oe);
      exp_ready = exp_q[k].size() < 2;
      chk("out_valid", k, ov, exp_q[k].size() > 0);
      chk("in_ready", k, ir, exp_ready);
      if (out_ready && exp_q[k].size() > 0) begin
        b = exp_q[k].pop_front();
        chk("out_data", k, od, b.d);
        chk("out_be", k, obe, b.be);
        chk("out_err", k, oe, b.err);
      end
      if (in_valid && exp_ready)
        exp_q[k].push_back(model(k == 2 ? 8 : 4, k == 1, in_addr, in_size, in_data));
    end
  endtask

  task automatic step(input logic v, input logic [2:0] a, input logic [1:0] s,
                      input logic [63:0] d, input logic r);
    in_valid  = v;
    in_addr   = a;
    in_size   = s;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    logic ov, ir, oe;
    logic [63:0] od;
    logic [7:0] obe;
    for (int k = 0; k < 3; k++) begin
      observe(k, ov, ir, od, obe, oe);
      chk("rst_valid", k, ov, 1'b0);
      chk("rst_ready", k, ir, 1'b1);
      chk("rst_data", k, od, 64'd0);
      chk("rst_be", k, obe, 8'd0);
      chk("rst_err", k, oe, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_size = '0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state();

    // Directed lane and enable vectors, each drained the following cycle.
    step(1'b1, 3'd2, 2'd0, 64'h0000_00A5, 1'b1);
    chk("tp_byte_data", 0, if_le32.out_data, 64'hA5A5_A5A5);
    chk("tp_byte_be", 0, if_le32.out_be, 64'b0100);
    chk("tp_byte_be_big", 1, if_be32.out_be, 64'b0010);
    step(1'b1, 3'd2, 2'd1, 64'hFFFF_1234, 1'b1);
    chk("tp_half_data", 0, if_le32.out_data, 64'h1234_1234);
    chk("tp_half_be", 0, if_le32.out_be, 64'b1100);
    step(1'b1, 3'd1, 2'd1, 64'hFFFF_1234, 1'b1);
    chk("tp_half_mis_err", 0, if_le32.out_err, 1'b1);
    chk("tp_half_mis_be", 0, if_le32.out_be, 64'd0);
    step(1'b1, 3'd0, 2'd2, 64'hDEAD_BEEF, 1'b1);
    chk("tp_word_be", 0, if_le32.out_be, 64'b1111);
    step(1'b1, 3'd0, 2'd0, 64'h0000_0077, 1'b1);
    chk("tp_big_byte_be", 1, if_be32.out_be, 64'b1000);
    step(1'b1, 3'd0, 2'd1, 64'h0000_5566, 1'b1);
    chk("tp_big_half_be", 1, if_be32.out_be, 64'b1100);
    step(1'b1, 3'd0, 2'd3, 64'h0123_4567_89AB_CDEF, 1'b1);
    chk("tp_dword_be", 2, if_le64.out_be, 64'hFF);
    chk("tp_illegal_err", 0, if_le32.out_err, 1'b1);
    chk("tp_illegal_data", 0, if_le32.out_data, 64'h89AB_CDEF);
    step(1'b1, 3'd4, 2'd2, 64'h1122_3344, 1'b1);
    chk("tp_w64_data", 2, if_le64.out_data, 64'h1122_3344_1122_3344);
    chk("tp_w64_be", 2, if_le64.out_be, 64'hF0);
    step(1'b1, 3'd2, 2'd2, 64'h1122_3344, 1'b1);
    chk("tp_w64_mis_err", 2, if_le64.out_err, 1'b1);
    step(1'b0, 3'd0, 2'd0, 64'd0, 1'b1);

    // Backpressure: A held in OUT, B in skid, C stalls until the consumer resumes.
    step(1'b1, 3'd0, 2'd2, 64'hAAAA_0001, 1'b0);
    step(1'b1, 3'd0, 2'd2, 64'hBBBB_0002, 1'b0);
    chk("bp_stall_ready", 0, if_le32.in_ready, 1'b0);
    chk("bp_hold_data", 0, if_le32.out_data, 64'hAAAA_0001);
    step(1'b1, 3'd0, 2'd2, 64'hCCCC_0003, 1'b0);
    step(1'b1, 3'd0, 2'd2, 64'hCCCC_0003, 1'b1);
    chk("bp_b_next", 0, if_le32.out_data, 64'hBBBB_0002);
    step(1'b1, 3'd0, 2'd2, 64'hCCCC_0003, 1'b1);
    chk("bp_c_next", 0, if_le32.out_data, 64'hCCCC_0003);
    step(1'b0, 3'd0, 2'd0, 64'd0, 1'b1);

    // Reset while FULL discards both beats.
    step(1'b1, 3'd1, 2'd0, 64'h0000_0011, 1'b0);
    step(1'b1, 3'd3, 2'd0, 64'h0000_0022, 1'b0);
    in_valid = 1'b1;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) exp_q[k].delete();
    check_reset_state();
    step(1'b1, 3'd3, 2'd0, 64'h0000_003C, 1'b1);
    chk("post_rst_data", 0, if_le32.out_data, 64'h3C3C_3C3C);
    chk("post_rst_be", 0, if_le32.out_be, 64'b1000);

    // Randomized traffic with random backpressure.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           {$urandom, $urandom}, $urandom_range(0, 2) != 0);
    end
    repeat (4) step(1'b0, 3'd0, 2'd0, 64'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
